// File: rtl/instr_enc_pkg.sv
// Shared types, RV32I opcode constants and the pure encode / range-check
// functions used by the instruction encoder.
//   fmt_e         : instruction format selector (R/I/S/B)
//   state_e       : loader state
//   encode()      : packs decoded fields into an RV32I word
//   imm_in_range(): true when the immediate fits the selected format
package instr_enc_pkg;

  typedef enum logic [1:0] {
    FmtR = 2'd0,
    FmtI = 2'd1,
    FmtS = 2'd2,
    FmtB = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;

  // Only imm[12:0] can ever land in the word; the upper bits matter only to the range check.
  function automatic logic [31:0] encode(input fmt_e       fmt,
                                         input logic [6:0]  opcode,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  funct3,
                                         input logic [6:0]  funct7,
                                         input logic [12:0] imm);
    logic [31:0] w;
    case (fmt)
      FmtR:    w = {funct7, rs2, rs1, funct3, rd, opcode};
      FmtI:    w = {imm[11:0], rs1, funct3, rd, opcode};
      FmtS:    w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      default: w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
    endcase
    return w;
  endfunction

  // Sign-extension check: all bits above the field's sign bit must match it.
  function automatic logic imm_in_range(input fmt_e fmt, input logic [31:0] imm);
    logic ok;
    case (fmt)
      FmtR:       ok = 1'b1;
      FmtI, FmtS: ok = (&imm[31:11]) | ~(|imm[31:11]);
      default:    ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush, registered output (no fall-through).
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : empties the FIFO, wins over push/pop
//   push_i/wdata_i: write when not full
//   pop_i         : drop head when not empty
//   rdata_o       : head entry
//   full_o/empty_o/count_o : occupancy
module instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW:0]    count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW:0]    r_wptr, r_rptr;
  logic             w_push, w_pop;

  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign count_o = r_wptr - r_rptr;
  assign empty_o = (r_wptr == r_rptr);
  // Extra pointer bit distinguishes full from empty.
  assign full_o  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                   (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
  assign rdata_o = r_mem[r_rptr[PtrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes decoded instruction bundles into RV32I words and streams them
// sequentially into instruction memory.
//   start_i/stop_i/base_addr_i : run control, base address sampled on start
//   in_valid_i/in_ready_o      : bundle handshake (fmt, opcode, regs, functs, imm)
//   imem_we_o/imem_ready_i     : memory write handshake, imem_addr_o/imem_wdata_o
//   done_o  : high in DONE;  err_o : sticky rejected-bundle flag
//   count_o : words written since start
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int unsigned   CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] Span = {1'b1, {ADDR_W{1'b0}}};

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_remain;  // words still allowed before the address space ends
  logic              r_err;

  logic              w_limit, w_accept, w_ok, w_push, w_pop;
  logic              w_full, w_empty;
  logic [31:0]       w_head, w_word;
  logic [CntW-1:0]   w_fifo_cnt;
  fmt_e              w_fmt;

  assign w_fmt      = fmt_e'(fmt_i);
  assign w_limit    = (r_remain == '0);
  assign in_ready_o = (r_state == StRun) & ~w_full & ~w_limit;
  assign w_accept   = in_valid_i & in_ready_o & ~start_i;
  assign w_ok       = imm_in_range(w_fmt, imm_i);
  assign w_push     = w_accept & w_ok;
  assign w_word     = encode(w_fmt, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i,
                             imm_i[12:0]);

  assign imem_we_o    = ~w_empty;
  assign w_pop        = imem_we_o & imem_ready_i & ~start_i;
  assign imem_wdata_o = imem_we_o ? w_head : '0;
  assign imem_addr_o  = r_addr;
  assign done_o       = (r_state == StDone);
  assign err_o        = r_err;
  assign count_o      = r_count;

  instr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (start_i),
    .push_i  (w_push),
    .wdata_i (w_word),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_fifo_cnt)
  );

  always_comb begin
    w_state_d = r_state;
    if (start_i) begin
      w_state_d = StRun;
    end else begin
      unique case (r_state)
        StIdle:  w_state_d = StIdle;
        StRun:   if (stop_i || w_limit) w_state_d = StDrain;
        // Look ahead at the final pop so done_o rises right after it.
        StDrain: if (w_empty || (w_pop && w_fifo_cnt == CntW'(1))) w_state_d = StDone;
        StDone:  w_state_d = StDone;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_count  <= '0;
      r_remain <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (start_i) begin
        r_addr   <= base_addr_i;
        r_count  <= '0;
        r_remain <= Span - {1'b0, base_addr_i};
        r_err    <= 1'b0;
      end else begin
        if (w_pop) begin
          r_addr  <= r_addr + 1'b1;
          r_count <= r_count + 1'b1;
        end
        if (w_push) r_remain <= r_remain - 1'b1;
        if (w_accept && !w_ok) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader for the single-cycle core's instruction memory. It accepts decoded instruction fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake. It packs them into 32-bit RV32I words, scattering the immediate into the R/I/S/B bit positions as the inverse of immediate generation, and buffers them in a small FIFO. It then writes the words sequentially into instruction memory behind a write/ready handshake. It is the program-loading path used by test harnesses and the boot loader.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- FIFO_DEPTH, 2, encoded-word buffer entries (power of two, ≥2)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  pulse: flush, load base address, clear errors, enter RUN
- stop_i  in  1  pulse: stop accepting, drain FIFO, enter DONE
- base_addr_i  in  ADDR_W  first write address, sampled on start_i
- in_valid_i  in  1  field bundle valid
- in_ready_o  out  1  bundle accepted when in_valid_i & in_ready_o
- fmt_i  in  2  0=R, 1=I, 2=S, 3=B
- opcode_i  in  7  inst[6:0]
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3; funct7_i  in  7
- imm_i  in  32  signed immediate (byte offset for B)
- imem_we_o  out  1  write request
- imem_ready_i  in  1  memory accepts write when imem_we_o & imem_ready_i
- imem_addr_o  out  ADDR_W  word address
- imem_wdata_o  out  32  encoded instruction
- done_o  out  1  level, high in DONE
- err_o  out  1  sticky: a bundle was rejected
- count_o  out  ADDR_W+1  words written since start_i

## Operation
- States: IDLE (reset), RUN, DRAIN, DONE. start_i from any state → RUN. stop_i in RUN → DRAIN. DRAIN with FIFO empty → DONE. In RUN, limit reached (accepted words = 2^ADDR_W − base) → DRAIN.
- in_ready_o = (state==RUN) & !fifo_full & !limit. Registered-state function only; it never depends on in_valid_i.
- Encoding: R = {f7,rs2,rs1,f3,rd,op}. I = {imm[11:0],rs1,f3,rd,op}. S = {imm[11:5],rs2,rs1,f3,imm[4:0],op}. B = {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}. R ignores imm_i. I/S/B ignore unused fields.
- Range check: I/S need imm_i[31:11] all equal. B needs imm_i[31:12] all equal and imm_i[0]=0.
- On failure the bundle is still handshaken (consumed) but dropped. err_o sets. No FIFO push. The accept counter does not advance.
- Writer presents the FIFO head. On imem_we_o & imem_ready_i: pop, address +1, count_o +1. The address does not wrap, because the limit prevents it.
- start_i mid-write abandons the pending word and empties the FIFO. imem_we_o is low the cycle after. start_i also overrides stop_i in the same cycle.
- stop_i outside RUN is ignored.

## Timing
- Reset values: in_ready_o 0, imem_we_o 0, imem_addr_o 0, imem_wdata_o 0, done_o 0, err_o 0, count_o 0, state IDLE.
- Latency: bundle accepted at edge N → imem_we_o high from cycle N+1 (FIFO registered, no fall-through).
- imem_addr_o and imem_wdata_o stay stable while imem_we_o & !imem_ready_i.
- Full FIFO: in_ready_o low even if a pop occurs the same cycle (no simultaneous push-on-pop when full). It rises the cycle after the pop.
- Empty FIFO with a push: no combinational bypass to imem.
- done_o rises the cycle after the final pop in DRAIN.
- err_o is set the cycle after the bad bundle and is cleared only by start_i or reset.

## Structure
- Package instr_enc_pkg holds:
  - fmt_e enum (R/I/S/B)
  - state_e enum
  - RV32I opcode constants (OP_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, OP 0110011)
  - encode and range-check functions
- Sub-module instr_fifo: parameterised synchronous FIFO with push/pop/flush, full/empty.

## Test plan
- I-type addi x1,x0,5 (fmt 1, op 0x13, rd 1, imm 5), start_i at base 0x10 → one write, wdata 0x00500093, addr 0x10, count_o 1.
- S-type sw x2,-4(x3) (op 0x23, f3 2, rs1 3, rs2 2, imm −4) → wdata 0xFE21AE23. B-type beq x1,x2,+8 (op 0x63) → wdata 0x00208463.
- I-type imm 2048, then B-type imm 3 → both handshaken, no writes, err_o=1, next valid bundle written at unchanged address.
- imem_ready_i low 5 cycles, 3 bundles offered → in_ready_o drops after 2 accepts, wdata/addr held, all 3 written in order once ready returns.
- ADDR_W=2, base 2, 4 bundles offered → writes to addr 2,3 only, in_ready_o low after 2nd accept, done_o=1, count_o 2.
- start_i during a stalled write with a full FIFO → imem_we_o low next cycle, FIFO empty, addr = new base, err_o cleared.
